// File: rtl/pc_sequencer_pkg.sv
// Shared CPU package: PC sequencer state encodings and reset-vector default.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALLED = 2'd1,
    ST_HALTED  = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selection: pc+4, branch adder, priority mux
// (jr > jump > branch > sequential) and word-alignment check.
module next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [31:0] pc_jump,
  input  logic        jr,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        misalign
);

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] off);
    logic signed [31:0] off_words;
    off_words = off <<< 2;
    return base + off_words;
  endfunction

  logic chk_align;

  assign pc_plus4 = pc + PC_STEP;

  // Jump targets are aligned by construction, so only jr/branch are checked.
  always_comb begin
    target    = pc_plus4;
    chk_align = 1'b0;
    if (jr) begin
      target    = reg_target;
      chk_align = 1'b1;
    end else if (jump) begin
      target = pc_jump;
    end else if (branch_taken) begin
      target    = branch_target(pc_plus4, branch_offset);
      chk_align = 1'b1;
    end
  end

  assign misalign = chk_align && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/STALLED/HALTED FSM owning the PC,
// retired-instruction counter and sticky misalignment flag.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [31:0] pc_jump,
  input  logic        jr,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  state,
  output logic        misalign,
  output logic [31:0] inst_count
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  logic        misalign_q;
  logic [31:0] target_d;
  logic        misalign_d;

  next_pc_sel u_sel (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .pc_jump       (pc_jump),
    .jr            (jr),
    .reg_target    (reg_target),
    .pc_plus4      (pc_plus4),
    .target        (target_d),
    .misalign      (misalign_d)
  );

  // halt_req outranks stall; a misaligned target halts without moving the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_STALLED: begin
          if (halt_req) begin
            state_q <= ST_HALTED;
          end else if (stall) begin
            state_q <= ST_STALLED;
          end else if (misalign_d) begin
            misalign_q <= 1'b1;
            state_q    <= ST_HALTED;
          end else begin
            pc_q    <= target_d;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_HALTED;
      endcase
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign misalign   = misalign_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus a wrap-around reset instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [31:0] pc_jump = '0;
  logic        jr = 1'b0;
  logic [31:0] reg_target = '0;

  logic [31:0] pc, pc_plus4, inst_count;
  logic [1:0]  state;
  logic        misalign;
  logic [31:0] w_pc, w_pc_plus4, w_inst_count;
  logic [1:0]  w_state;
  logic        w_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .pc_jump(pc_jump), .jr(jr), .reg_target(reg_target),
    .pc(pc), .pc_plus4(pc_plus4), .state(state), .misalign(misalign),
    .inst_count(inst_count)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .pc_jump(pc_jump), .jr(jr), .reg_target(reg_target),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .state(w_state), .misalign(w_misalign),
    .inst_count(w_inst_count)
  );

  typedef struct {
    string       name;
    logic        rst, stall, halt, br;
    logic [31:0] off;
    logic        jmp;
    logic [31:0] pcj;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic s, logic h, logic b,
                              logic [31:0] o, logic j, logic [31:0] pj,
                              logic jrr, logic [31:0] t, logic [31:0] epc,
                              logic [1:0] est, logic emis, logic [31:0] ecnt);
    vec_t v;
    v.name = n; v.rst = r; v.stall = s; v.halt = h; v.br = b; v.off = o;
    v.jmp = j; v.pcj = pj; v.jr = jrr; v.rt = t;
    v.e_pc = epc; v.e_st = est; v.e_mis = emis; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = v.stall; halt_req = v.halt;
    branch_taken = v.br; branch_offset = v.off;
    jump = v.jmp; pc_jump = v.pcj; jr = v.jr; reg_target = v.rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name         rst st  hl  br  off            jmp pc_jump       jr  reg_target    pc            st    mis cnt
    vecs.push_back(mk("reset",   1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0000, 2'd0, 0, 0));
    vecs.push_back(mk("seq1",    0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0004, 2'd0, 0, 1));
    vecs.push_back(mk("seq2",    0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0008, 2'd0, 0, 2));
    vecs.push_back(mk("seq3",    0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_000C, 2'd0, 0, 3));
    vecs.push_back(mk("jmp100",  0, 0, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0000_0100, 2'd0, 0, 4));
    vecs.push_back(mk("br_neg",  0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,         0, 32'h0,         32'h0000_00FC, 2'd0, 0, 5));
    vecs.push_back(mk("jmp100b", 0, 0, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0000_0100, 2'd0, 0, 6));
    vecs.push_back(mk("br_pos",  0, 0, 0, 1, 32'h3,         0, 32'h0,         0, 32'h0,         32'h0000_0110, 2'd0, 0, 7));
    vecs.push_back(mk("jmp200",  0, 0, 0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0000_0200, 2'd0, 0, 8));
    vecs.push_back(mk("prio_jr", 0, 0, 0, 1, 32'h3,         1, 32'h800,       1, 32'h400,       32'h0000_0400, 2'd0, 0, 9));
    vecs.push_back(mk("prio_jmp",0, 0, 0, 1, 32'h3,         1, 32'h800,       0, 32'h0,         32'h0000_0800, 2'd0, 0, 10));
    vecs.push_back(mk("jmp20",   0, 0, 0, 0, 32'h0,         1, 32'h20,        0, 32'h0,         32'h0000_0020, 2'd0, 0, 11));
    vecs.push_back(mk("stall1",  0, 1, 0, 0, 32'h0,         1, 32'h900,       0, 32'h0,         32'h0000_0020, 2'd1, 0, 11));
    vecs.push_back(mk("stall2",  0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h500,       32'h0000_0020, 2'd1, 0, 11));
    vecs.push_back(mk("unstall", 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0024, 2'd0, 0, 12));
    vecs.push_back(mk("stall3",  0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0024, 2'd1, 0, 12));
    vecs.push_back(mk("halt_st", 0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0024, 2'd2, 0, 12));
    vecs.push_back(mk("hlt_jmp", 0, 0, 0, 0, 32'h0,         1, 32'h900,       0, 32'h0,         32'h0000_0024, 2'd2, 0, 12));
    vecs.push_back(mk("hlt_jr",  0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h404,       32'h0000_0024, 2'd2, 0, 12));
    vecs.push_back(mk("rst2",    1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0000, 2'd0, 0, 0));
    vecs.push_back(mk("jmp40",   0, 0, 0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0000_0040, 2'd0, 0, 1));
    vecs.push_back(mk("mis_jr",  0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h402,       32'h0000_0040, 2'd2, 1, 1));
    vecs.push_back(mk("mis_hold",0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0040, 2'd2, 1, 1));
    vecs.push_back(mk("rst3",    1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0000, 2'd0, 0, 0));
    vecs.push_back(mk("halt_run",0, 0, 1, 0, 32'h0,         1, 32'h300,       0, 32'h0,         32'h0000_0000, 2'd2, 0, 0));
    vecs.push_back(mk("rst_ovr", 1, 1, 1, 0, 32'h0,         1, 32'h300,       0, 32'h0,         32'h0000_0000, 2'd0, 0, 0));
    vecs.push_back(mk("jmp_top", 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 2'd0, 0, 1));
    vecs.push_back(mk("wrap",    0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0000, 2'd0, 0, 2));

    // Wrap-around instance: reset vector at the top of the address space.
    drive(vecs[0]);
    check("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("w_rst_pc4", w_pc_plus4, 32'h0000_0000);
    check("rst_pc4", pc_plus4, 32'h0000_0004);
    drive(vecs[1]);
    check("w_wrap_pc", w_pc, 32'h0000_0000);
    check("w_wrap_mis", {31'b0, w_misalign}, 32'h0);
    check("w_wrap_cnt", w_inst_count, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check({vecs[i].name, ".pc"},  pc, vecs[i].e_pc);
      check({vecs[i].name, ".st"},  {30'b0, state}, {30'b0, vecs[i].e_st});
      check({vecs[i].name, ".mis"}, {31'b0, misalign}, {31'b0, vecs[i].e_mis});
      check({vecs[i].name, ".cnt"}, inst_count, vecs[i].e_cnt);
      check({vecs[i].name, ".pc4"}, pc_plus4, vecs[i].e_pc + 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
